uart_rx_fifo: RTL and testbench

//  Receives 8N1 async serial data (the o_txd stream of service_ihp_top) and queues bytes in a small FIFO.

---
 rtl/uart_rx_fifo.sv | 212 +++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Purpose : 8N1 UART receiver feeding a small byte FIFO with a valid/ready consumer port.
// Latency : i_rxd mid-stop-bit -> o_valid high after 4 i_clk (2 sync, 1 stop sample, 1 push).
// Backpres: i_ready low lets the FIFO fill; a byte finishing while full is dropped with o_overrun.
//
// Ports:
//   i_clk, i_rst      single clock, synchronous active-high reset
//   i_rxd             asynchronous serial line, idle high
//   o_data/o_valid    FIFO head byte and not-empty flag
//   i_ready           consumer accepts the head (pop on o_valid & i_ready)
//   o_count           bytes currently held
//   o_frame_err       1-cycle pulse, stop bit sampled low (byte discarded)
//   o_overrun         1-cycle pulse, byte completed while FIFO full (byte dropped)
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_rxd,
  output logic [7:0]                    o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_frame_err,
  output logic                          o_overrun
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int NW   = PW + 1;

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [NW-1:0] FULL_CNT  = NW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BRK
  } state_e;

  // Receiver state
  logic          rx_meta_q, rx_meta_d;
  logic          rx_s_q,    rx_s_d;
  state_e        state_q,   state_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q,   shift_d;

  // Completed byte handed to the FIFO one cycle after the stop sample
  logic          push_req_q, push_req_d;
  logic [7:0]    push_dat_q, push_dat_d;

  logic          frame_err_q, frame_err_d;
  logic          overrun_q,   overrun_d;

  // FIFO state
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [NW-1:0] count_q,  count_d;

  logic cnt_wrap;
  logic pop;
  logic full;
  logic push_ok;

  // Receiver FSM
  always_comb begin
    rx_meta_d   = i_rxd;
    rx_s_d      = rx_meta_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    push_req_d  = 1'b0;
    push_dat_d  = push_dat_q;
    frame_err_d = 1'b0;
    cnt_wrap    = (cnt_q == BIT_LAST);

    unique case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      S_START: begin
        // Re-check the line at mid start bit so a short glitch is ignored.
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (cnt_wrap) begin
          cnt_d     = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};  // LSB arrives first
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        if (cnt_wrap) begin
          cnt_d = '0;
          if (rx_s_q) begin
            push_req_d = 1'b1;
            push_dat_d = shift_q;
            state_d    = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BRK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_BRK: begin
        // A low line after a bad stop bit is a break; wait for idle before rearming.
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // FIFO: a pop in the same cycle frees the slot, so a push into a full FIFO
  // is only dropped when the consumer is not taking the head.
  always_comb begin
    pop       = (count_q != '0) && i_ready;
    full      = (count_q == FULL_CNT);
    push_ok   = push_req_q && (!full || pop);
    overrun_d = push_req_q && full && !pop;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = push_dat_q;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      push_req_q  <= 1'b0;
      push_dat_q  <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      push_req_q  <= push_req_d;
      push_dat_q  <= push_dat_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  assign o_data      = mem_q[rd_ptr_q];
  assign o_valid     = (count_q != '0);
  assign o_count     = count_q;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Purpose : self-checking bench for uart_rx_fifo (CLKS_PER_BIT=16, FIFO_DEPTH=4).
// Latency : expects o_valid 156 cycles after the start bit is launched.
// Backpres: drives i_ready patterns to exercise fill, overrun and same-cycle push/pop.
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int HALF  = CPB / 2;
  // Start bit launched after edge N is first seen at edge N+1; then 2 sync cycles,
  // one detect cycle, half a bit, nine bit periods to the stop midpoint.
  localparam int ERR_LAT  = 3 + HALF + 9 * CPB;
  localparam int PUSH_LAT = ERR_LAT + 1;

  logic       clk;
  logic       i_rst;
  logic       i_rxd;
  logic       i_ready;
  logic [7:0] o_data;
  logic       o_valid;
  logic [2:0] o_count;
  logic       o_frame_err;
  logic       o_overrun;

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_rxd      (i_rxd),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_count    (o_count),
    .o_frame_err(o_frame_err),
    .o_overrun  (o_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         cyc;
    logic       err;
    logic [7:0] dat;
  } ev_t;

  ev_t        sched[$];
  logic [7:0] mq[$];
  logic [7:0] popped[$];

  logic rst_e, rdy_e;
  logic exp_fe, exp_ov, pop_e, push_e;
  logic [7:0] push_b;
  logic valid_prev = 1'b0;
  int rise_cyc = 0;
  int valid_cycles = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int cnt_max = 0;
  int last_n0 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Inputs as seen by each rising edge.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_e <= i_rst;
    rdy_e <= i_ready;
  end

  // Queue-level model of the FIFO, advanced by the edge that just happened,
  // then compared against the DUT outputs.
  always @(negedge clk) begin
    if (cyc > 0) begin
      exp_fe = 1'b0;
      exp_ov = 1'b0;
      if (rst_e) begin
        mq.delete();
        sched.delete();
      end else begin
        pop_e  = (mq.size() != 0) && rdy_e;
        push_e = 1'b0;
        push_b = 8'h00;
        while (sched.size() != 0 && sched[0].cyc <= cyc) begin
          if (sched[0].cyc == cyc) begin
            if (sched[0].err) exp_fe = 1'b1;
            else begin
              push_e = 1'b1;
              push_b = sched[0].dat;
            end
          end
          void'(sched.pop_front());
        end
        if (pop_e) void'(mq.pop_front());
        if (push_e) begin
          if (mq.size() == DEPTH) exp_ov = 1'b1;
          else mq.push_back(push_b);
        end
      end

      check("valid", 32'(o_valid), 32'(mq.size() != 0));
      check("count", 32'(o_count), 32'(mq.size()));
      check("frame_err", 32'(o_frame_err), 32'(exp_fe));
      check("overrun", 32'(o_overrun), 32'(exp_ov));
      if (mq.size() != 0) check("data", 32'(o_data), 32'(mq[0]));

      // Statistics for the directed literal checks.
      if (o_valid && i_ready && !i_rst) popped.push_back(o_data);
      if (o_valid && !valid_prev) rise_cyc = cyc;
      valid_prev = o_valid;
      valid_cycles += int'(o_valid);
      fe_cnt += int'(o_frame_err);
      ov_cnt += int'(o_overrun);
      if (int'(o_count) > cnt_max) cnt_max = int'(o_count);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_rxd = 1'b1;
    repeat (n) tick();
  endtask

  // Ideal 8N1 frame; pct scales the bit period (100 = nominal). Line is left at the stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int pct);
    int n0;
    int dur;
    tick();
    n0 = cyc;
    last_n0 = n0;
    sched.push_back('{cyc: n0 + (stop ? PUSH_LAT : ERR_LAT), err: !stop, dat: b});
    for (int j = 0; j < 10; j++) begin
      dur = ((j + 1) * CPB * pct + 50) / 100 - (j * CPB * pct + 50) / 100;
      if (j == 0) i_rxd = 1'b0;
      else if (j == 9) i_rxd = stop;
      else i_rxd = b[j-1];
      repeat (dur) tick();
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1, 100);
    idle(20);
  endtask

  task automatic clear_stats();
    fe_cnt = 0;
    ov_cnt = 0;
    valid_cycles = 0;
    cnt_max = 0;
    popped.delete();
  endtask

  // vals holds the expected bytes, first popped in the low byte.
  task automatic check_pops(input string name, input int n, input logic [63:0] vals);
    check({name, "_num"}, 32'(popped.size()), 32'(n));
    for (int k = 0; k < n && k < popped.size(); k++) begin
      check(name, 32'(popped[k]), 32'(vals[8*k +: 8]));
    end
    popped.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no end of stimulus, expected finish within 100000 cycles");
    $fatal(1, "timeout");
  end

  logic [7:0] b99;

  initial begin
    b99     = 8'h99;
    i_rst   = 1'b1;
    i_rxd   = 1'b1;
    i_ready = 1'b0;
    repeat (3) tick();
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_count", 32'(o_count), 32'd0);
    check("rst_data", 32'(o_data), 32'd0);
    check("rst_frame_err", 32'(o_frame_err), 32'd0);
    check("rst_overrun", 32'(o_overrun), 32'd0);
    i_rst = 1'b0;
    idle(5);

    // 1: three back-to-back bytes, consumer always ready
    i_ready = 1'b1;
    clear_stats();
    send_frame(8'hA5, 1'b1, 100);
    idle(20);
    check("t1_latency", 32'(rise_cyc - last_n0), 32'd156);
    send_byte(8'h00);
    send_byte(8'hFF);
    check_pops("t1_order", 3, {8'hFF, 8'h00, 8'hA5});
    check("t1_valid_cycles", 32'(valid_cycles), 32'd3);
    check("t1_flags", 32'(fe_cnt + ov_cnt), 32'd0);

    // 2: 5-cycle glitch is a false start
    clear_stats();
    i_rxd = 1'b0;
    repeat (5) tick();
    idle(30);
    check("t2_no_valid", 32'(valid_cycles), 32'd0);
    check("t2_flags", 32'(fe_cnt + ov_cnt), 32'd0);
    send_byte(8'h3C);
    check_pops("t2_after_glitch", 1, 64'h3C);

    // 3: bad stop bit followed by a held-low break
    clear_stats();
    send_frame(8'h55, 1'b0, 100);
    repeat (40) tick();
    idle(30);
    check("t3_frame_err", 32'(fe_cnt), 32'd1);
    check("t3_no_valid", 32'(valid_cycles), 32'd0);
    check("t3_overrun", 32'(ov_cnt), 32'd0);
    send_byte(8'h12);
    check_pops("t3_after_break", 1, 64'h12);

    // 4: fill past capacity with consumer stalled
    clear_stats();
    i_ready = 1'b0;
    for (int b = 1; b <= 5; b++) send_byte(8'(b));
    check("t4_count_max", 32'(cnt_max), 32'd4);
    check("t4_overrun", 32'(ov_cnt), 32'd1);
    check("t4_count_full", 32'(o_count), 32'd4);
    check("t4_frame_err", 32'(fe_cnt), 32'd0);
    i_ready = 1'b1;
    idle(10);
    check_pops("t4_drain", 4, {8'h04, 8'h03, 8'h02, 8'h01});
    check("t4_count_empty", 32'(o_count), 32'd0);

    // 5: pop exactly on the push cycle of a byte arriving into a full FIFO
    clear_stats();
    i_ready = 1'b0;
    for (int b = 0; b < 4; b++) send_byte(8'hA1 + 8'(b));
    fork
      send_frame(8'hEE, 1'b1, 100);
      begin
        tick();
        repeat (PUSH_LAT - 1) tick();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
      end
    join
    idle(20);
    check("t5_overrun", 32'(ov_cnt), 32'd0);
    check("t5_count_max", 32'(cnt_max), 32'd4);
    check("t5_count", 32'(o_count), 32'd4);
    i_ready = 1'b1;
    idle(10);
    check_pops("t5_drain", 5, {8'hEE, 8'hA4, 8'hA3, 8'hA2, 8'hA1});

    // 6: reset in the middle of data bit 4 of 0x99, with a byte already queued
    clear_stats();
    i_ready = 1'b0;
    send_byte(8'h77);
    check("t6_pre_count", 32'(o_count), 32'd1);
    i_rxd = 1'b0;
    repeat (CPB) tick();
    for (int k = 0; k < 4; k++) begin
      i_rxd = b99[k];
      repeat (CPB) tick();
    end
    i_rxd = b99[4];
    repeat (HALF) tick();
    i_rst = 1'b1;
    tick();
    check("t6_rst_valid", 32'(o_valid), 32'd0);
    check("t6_rst_count", 32'(o_count), 32'd0);
    check("t6_rst_data", 32'(o_data), 32'd0);
    repeat (CPB - HALF - 1) tick();
    for (int k = 5; k < 8; k++) begin
      i_rxd = b99[k];
      repeat (CPB) tick();
    end
    idle(CPB);
    i_rst = 1'b0;
    idle(10);
    i_ready = 1'b1;
    send_byte(8'h42);
    check_pops("t6_only_42", 1, 64'h42);
    check("t6_flags", 32'(fe_cnt + ov_cnt), 32'd0);

    // Baud tolerance: -3% and +3% bit period
    clear_stats();
    send_frame(8'hA5, 1'b1, 97);
    idle(20);
    send_frame(8'hA5, 1'b1, 103);
    idle(20);
    check_pops("baud_tol", 2, {8'hA5, 8'hA5});
    check("baud_flags", 32'(fe_cnt + ov_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
